// File: rtl/sram_like_arbiter_if.sv
// Purpose: one sram-like port (request fields plus address/data handshakes).
// Latency: wires only, no storage.
// Backpressure: addr_ok from the slave accepts the address phase; data_ok returns responses in order.
interface sram_like_arbiter_if;
   logic        req;
   logic        wr;
   logic [2:0]  size;
   logic [31:0] addr;
   logic [3:0]  wstrb;
   logic [31:0] wdata;
   logic        addr_ok;
   logic        data_ok;
   logic [31:0] rdata;

   // Requester side: issues the address phase, receives the handshakes and read data.
   modport master (
      output req, wr, size, addr, wstrb, wdata,
      input  addr_ok, data_ok, rdata
   );

   // Memory side: accepts the address phase, returns the handshakes and read data.
   modport slave (
      input  req, wr, size, addr, wstrb, wdata,
      output addr_ok, data_ok, rdata
   );
endinterface

// File: rtl/sram_like_arbiter.sv
// Purpose: shares one sram-like memory port between the inst and data requesters; responses steered by an in-order owner FIFO.
// Latency: zero; address phase and response routing are combinational through this block.
// Backpressure: grant locked until mem_addr_ok; no grant while OUTSTANDING transactions are in flight.
module sram_like_arbiter #(
   parameter int OUTSTANDING  = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                resetn,
   sram_like_arbiter_if.slave  inst,
   sram_like_arbiter_if.slave  data,
   sram_like_arbiter_if.master mem,
   output logic                err_unexp_rsp
);

   localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   // Owner FIFO: one bit per accepted transaction, oldest at rd_ptr.
   logic [OUTSTANDING-1:0] own_q;
   logic [PW-1:0]          wr_ptr;
   logic [PW-1:0]          rd_ptr;
   logic [CW-1:0]          count;
   logic                   full;
   logic                   head_own;

   // Address-phase lock and fairness state.
   logic          lock_valid;
   logic          lock_owner;
   logic          lock_valid_nxt;
   logic          lock_owner_nxt;
   logic [SW-1:0] starve_cnt;

   // Grant and handshake events.
   logic gnt_vld;
   logic gnt_own;
   logic hs;
   logic pop;

   assign full     = (count == CW'(OUTSTANDING));
   assign head_own = own_q[rd_ptr];
   assign hs       = mem.req & mem.addr_ok;
   assign pop      = resetn & mem.data_ok & (count != '0);

   // Lock state register: holds the grant while an address phase waits for mem_addr_ok.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lock_valid <= 1'b0;
         lock_owner <= OWN_INST;
      end else begin
         lock_valid <= lock_valid_nxt;
         lock_owner <= lock_owner_nxt;
      end
   end

   // Lock next state: set on a stalled request, cleared on the handshake; a dropped req leaves it alone.
   always_comb begin
      lock_valid_nxt = lock_valid;
      lock_owner_nxt = lock_owner;
      if (hs) begin
         lock_valid_nxt = 1'b0;
      end else if (mem.req) begin
         lock_valid_nxt = 1'b1;
         lock_owner_nxt = gnt_own;
      end
   end

   // Grant selection: lock wins, then a lone requester, then data unless inst has waited STARVE_LIMIT grants.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_own = OWN_INST;
      if (!full) begin
         if (lock_valid) begin
            gnt_vld = 1'b1;
            gnt_own = lock_owner;
         end else if (inst.req && data.req) begin
            gnt_vld = 1'b1;
            gnt_own = (starve_cnt == SW'(STARVE_LIMIT)) ? OWN_INST : OWN_DATA;
         end else if (inst.req) begin
            gnt_vld = 1'b1;
            gnt_own = OWN_INST;
         end else if (data.req) begin
            gnt_vld = 1'b1;
            gnt_own = OWN_DATA;
         end
      end
   end

   // Shared-port request mux; inst fields are the default when nothing is granted, all zero in reset.
   always_comb begin
      mem.req   = 1'b0;
      mem.wr    = 1'b0;
      mem.size  = 3'd0;
      mem.addr  = 32'd0;
      mem.wstrb = 4'd0;
      mem.wdata = 32'd0;
      if (resetn) begin
         if (gnt_vld && (gnt_own == OWN_DATA)) begin
            mem.req   = data.req;
            mem.wr    = data.wr;
            mem.size  = data.size;
            mem.addr  = data.addr;
            mem.wstrb = data.wstrb;
            mem.wdata = data.wdata;
         end else begin
            mem.req   = gnt_vld & inst.req;
            mem.wr    = inst.wr;
            mem.size  = inst.size;
            mem.addr  = inst.addr;
            mem.wstrb = inst.wstrb;
            mem.wdata = inst.wdata;
         end
      end
   end

   // Requester handshakes: addr_ok follows the grant, data_ok follows the FIFO head, rdata is broadcast.
   always_comb begin
      inst.addr_ok = hs & (gnt_own == OWN_INST);
      data.addr_ok = hs & (gnt_own == OWN_DATA);
      inst.data_ok = pop & (head_own == OWN_INST);
      data.data_ok = pop & (head_own == OWN_DATA);
      inst.rdata   = resetn ? mem.rdata : 32'd0;
      data.rdata   = resetn ? mem.rdata : 32'd0;
   end

   // Owner FIFO: push the granted owner on each handshake, pop on each response while non-empty.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         own_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (hs) begin
            own_q[wr_ptr] <= gnt_own;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (hs && !pop) begin
            count <= count + 1'b1;
         end else if (!hs && pop) begin
            count <= count - 1'b1;
         end
      end
   end

   // Starvation counter: counts data wins over a waiting inst, saturating; cleared when inst wins or stops asking.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         starve_cnt <= '0;
      end else if (hs && (gnt_own == OWN_DATA) && inst.req) begin
         if (starve_cnt != SW'(STARVE_LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
         end
      end else if ((hs && (gnt_own == OWN_INST)) || !inst.req) begin
         starve_cnt <= '0;
      end
   end

   // Sticky error: a response with no transaction in flight cannot be routed.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_unexp_rsp <= 1'b0;
      end else if (mem.data_ok && (count == '0)) begin
         err_unexp_rsp <= 1'b1;
      end
   end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like memory port between the CPU's instruction fetch requester (inst) and load/store requester (data).
- Sits between the pipeline's inst_sram/data_sram sram-like interfaces and the single sram-like port feeding the AXI bridge.
- Arbitrates address phases, locks the grant until the address handshake completes, and tracks up to OUTSTANDING in-flight transactions in an in-order owner FIFO.
- Uses that FIFO to route each data_ok/rdata back to the requester that issued the transaction.

Parameters:
- OUTSTANDING, 4: maximum accepted but not yet returned transactions; power of 2, at least 2.
- STARVE_LIMIT, 4: consecutive data grants allowed while inst is pending before inst is forced through.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- inst_req  in  1  inst request valid; held until inst_addr_ok.
- inst_wr  in  1  write flag.
- inst_size  in  3  transfer size.
- inst_addr  in  32  byte address.
- inst_wstrb  in  4  byte strobes.
- inst_wdata  in  32  write data.
- inst_addr_ok  out  1  inst address phase accepted.
- inst_data_ok  out  1  inst response valid.
- inst_rdata  out  32  inst read data.
- data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/3/32/4/32  same meaning as the inst_* inputs, for the data requester.
- data_addr_ok, data_data_ok, data_rdata  out  1/1/32  same meaning as the inst_* outputs, for the data requester.
- mem_req, mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  1/1/3/32/4/32  request fields of the shared port.
- mem_addr_ok  in  1  memory accepted the address phase.
- mem_data_ok  in  1  memory response valid; responses return in order.
- mem_rdata  in  32  response read data.
- err_unexp_rsp  out  1  sticky: mem_data_ok arrived while the FIFO was empty.

Behaviour:
- Reset: asynchronous on resetn=0. All registers clear:
  - FIFO pointers and count = 0.
  - lock_valid = 0, lock_owner = 0.
  - starve_cnt = 0.
  - err_unexp_rsp = 0.
- While in reset, every output is 0.
- Owner encoding: 0 = inst, 1 = data.
- Full: count == OUTSTANDING.
- Grant selection is combinational, evaluated only when not full:
  - lock_valid=1: grant = lock_owner, regardless of the other req.
  - Otherwise, only one req asserted: grant that requester.
  - Otherwise, both asserted: grant inst if starve_cnt == STARVE_LIMIT, else grant data.
- When full: mem_req = 0 and no grant, even if a pop occurs in the same cycle. This is a one-cycle bubble, accepted for simplicity.
- mem_req = granted requester's req. mem_wr/size/addr/wstrb/wdata are muxed from the granted requester; they are driven from inst when there is no grant.
- x_addr_ok = mem_addr_ok & mem_req & (grant == x). The other requester's addr_ok = 0.
- Lock:
  - mem_req=1 and mem_addr_ok=0 → lock_valid <= 1, lock_owner <= grant.
  - Handshake (mem_req & mem_addr_ok) → lock_valid <= 0.
  - While locked, mem_* fields come only from lock_owner.
- Starvation counter:
  - Handshake by data while inst_req=1 → starve_cnt++, saturating at STARVE_LIMIT.
  - Handshake by inst, or inst_req=0 → starve_cnt <= 0.
- Push: on a handshake, write the owner bit into the FIFO at the write pointer and increment it. Pointer width is log2(OUTSTANDING); pointers wrap modulo OUTSTANDING.
- Pop: on mem_data_ok with count > 0:
  - Head owner x gets x_data_ok = 1 and x_rdata = mem_rdata in the same cycle (combinational, zero latency).
  - Read pointer increments.
  - Both x_rdata outputs always carry mem_rdata; only data_ok is steered.
- Simultaneous push and pop (count < OUTSTANDING): both occur and count is unchanged.
- Pop with count 0: no data_ok to either requester, pointers unchanged, err_unexp_rsp <= 1 until reset.
- Requester deasserts req while locked: protocol violation. Lock is held, mem_req follows the now-low req (drops to 0), nothing is pushed.
- Reset mid-transaction: FIFO contents are discarded. Responses arriving afterwards set err_unexp_rsp; the system resets memory together with this block.
- Responses are never reordered: inst and data data_ok follow mem acceptance order exactly.

Test Plan:
- Single requester, back to back: inst_req held, mem_addr_ok=1 every cycle, mem_data_ok 2 cycles later with rdata=0x1000_0000+n → 4 inst_addr_ok pulses; inst_data_ok pulses carry matching rdata; data_data_ok never asserts.
- Contention and starvation: both reqs held, mem_addr_ok=1, immediate responses → grant order D,D,D,D,I,D,D,D,D,I; every data_ok goes to the issuing owner.
- Lock hold: data_req at cycle 0, inst_req at cycle 1, mem_addr_ok low for cycles 0-2 and high at cycle 3 → mem_addr equals data_addr in cycles 0-3; data_addr_ok at cycle 3; inst granted at cycle 4.
- Full FIFO: 4 handshakes with no mem_data_ok → mem_req=0 while inst_req=1. One mem_data_ok → mem_req stays 0 that cycle and asserts the next cycle.
- Interleaved in-order return: issue I,D,I,D, then four mem_data_ok with rdata 0xA,0xB,0xC,0xD → inst gets 0xA,0xC; data gets 0xB,0xD.
- Error and reset: mem_data_ok with an empty FIFO → err_unexp_rsp=1, no data_ok to either requester. Assert resetn=0 mid-burst → all outputs 0 immediately; after release, count=0 and err_unexp_rsp=0.
